hex_display_ctrl: RTL and testbench



---
 rtl/hex_display_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_hex_display_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - multi-digit 7-segment display controller (hex or decimal)
//
// Purpose:
//   Latches a WIDTH-bit unsigned value on an accepted LOAD strobe. It shows
//   the value on NDIGITS active-low 7-segment displays, in hexadecimal or
//   in decimal. Hex digits are ready on the next cycle. Decimal digits come
//   from a sequential shift-add-3 (double-dabble) converter that runs WIDTH
//   steps. A value that cannot be shown in NDIGITS digits turns every digit
//   into a dash.
//
// Optional build macro:
//   HEX_DISPLAY_LZ_BLANK_EN - blank the leading zero digits. Digit 0 is
//   never blanked.
//
// Parameters:
//   NDIGITS  number of digits driven (1..8)
//   WIDTH    width of VALUE in bits (4..32)
//
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   KEY0      in   asynchronous active-low reset
//   VALUE     in   value to display, sampled on an accepted LOAD
//   LOAD      in   load strobe, accepted only in IDLE
//   DEC_MODE  in   sampled with LOAD: 0 = hex, 1 = decimal
//   BUSY      out  high while a decimal conversion runs
//   DONE      out  one-cycle pulse on the cycle HEX changes
//   HEX       out  segments, active-low, digit i in [7i+6:7i], bits g..a

module hex_display_ctrl #(
  parameter int NDIGITS = 6,
  parameter int WIDTH   = 24
) (
  input  logic                   CLOCK_50,
  input  logic                   KEY0,
  input  logic [WIDTH-1:0]       VALUE,
  input  logic                   LOAD,
  input  logic                   DEC_MODE,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [7*NDIGITS-1:0]   HEX
);

  localparam int BW = 4 * NDIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  // Smallest value that needs more than NDIGITS decimal digits. For narrow
  // inputs it exceeds every VALUE, so the comparison can never be true.
  localparam logic [63:0] DEC_LIMIT = pow10(NDIGITS);

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_EMIT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] val_q;    // input bits still to be shifted into the BCD register
  logic [BW-1:0]    dig_q;    // one 4-bit code per digit (BCD or raw hex nibble)
  logic             ovf_q;
  logic [CW-1:0]    cnt_q;

  logic [31:0]      val_ext;
  logic             hex_ovf;
  logic             dec_ovf;
  logic [BW-1:0]    dig_adj;
  logic [BW-1:0]    dig_shift;
  logic [7*NDIGITS-1:0] hex_next;

  assign val_ext = 32'(VALUE);

  // Hex overflow: a set bit above the highest nibble shown on the display.
  assign hex_ovf = (val_ext >> BW) != 32'd0;
  assign dec_ovf = 64'(VALUE) >= DEC_LIMIT;

  // Double-dabble step: add 3 to every BCD digit of 5 or more, then shift
  // the next input bit in at the bottom. An overflowing value wraps inside
  // the BCD register. That does no harm because the dash flag takes
  // priority at display time.
  always_comb begin
    dig_adj = dig_q;
    for (int i = 0; i < NDIGITS; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
    end
  end

  assign dig_shift = {dig_adj[BW-2:0], val_q[WIDTH-1]};

  // Segment image for the EMIT cycle. Digits are scanned from the most
  // significant one downwards, so that leading zeros can be found.
  always_comb begin
`ifdef HEX_DISPLAY_LZ_BLANK_EN
    logic seen_nz;
    seen_nz = 1'b0;
`endif
    hex_next = '1;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      if (ovf_q) begin
        hex_next[7*i +: 7] = 7'h3F;
`ifdef HEX_DISPLAY_LZ_BLANK_EN
      end else if ((dig_q[4*i +: 4] == 4'd0) && !seen_nz && (i != 0)) begin
        hex_next[7*i +: 7] = 7'h7F;
`endif
      end else begin
        hex_next[7*i +: 7] = glyph(dig_q[4*i +: 4]);
      end
`ifdef HEX_DISPLAY_LZ_BLANK_EN
      if (dig_q[4*i +: 4] != 4'd0) seen_nz = 1'b1;
`endif
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state <= S_IDLE;
      val_q <= '0;
      dig_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      HEX   <= '1;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (LOAD) begin
            val_q <= VALUE;
            cnt_q <= '0;
            if (DEC_MODE) begin
              dig_q <= '0;
              ovf_q <= dec_ovf;
              BUSY  <= 1'b1;
              state <= S_CONV;
            end else begin
              // Hex nibbles are already digit codes. They go straight into
              // the digit register, so EMIT handles both modes the same way.
              dig_q <= val_ext[BW-1:0];
              ovf_q <= hex_ovf;
              state <= S_EMIT;
            end
          end
        end
        S_CONV: begin
          dig_q <= dig_shift;
          val_q <= {val_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            BUSY  <= 1'b0;
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          HEX   <= hex_next;
          DONE  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - self-checking bench for hex_display_ctrl
module tb_hex_display_ctrl;

`ifdef HEX_DISPLAY_LZ_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        KEY0;
  logic [23:0] VALUE;
  logic        LOAD;
  logic        DEC_MODE;
  logic        BUSY;
  logic        DONE;
  logic [41:0] HEX;

  logic [7:0]  value_s;
  logic        load_s;
  logic        dec_s;
  logic        busy_s;
  logic        done_s;
  logic [13:0] hex_s;

  int n_checks = 0;
  int n_fail   = 0;
  logic [41:0] cur_hex;

  logic [6:0] glyph_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_display_ctrl #(.NDIGITS(6), .WIDTH(24)) dut (
    .CLOCK_50(CLOCK_50), .KEY0(KEY0), .VALUE(VALUE), .LOAD(LOAD),
    .DEC_MODE(DEC_MODE), .BUSY(BUSY), .DONE(DONE), .HEX(HEX)
  );

  hex_display_ctrl #(.NDIGITS(2), .WIDTH(8)) dut_s (
    .CLOCK_50(CLOCK_50), .KEY0(KEY0), .VALUE(value_s), .LOAD(load_s),
    .DEC_MODE(dec_s), .BUSY(busy_s), .DONE(done_s), .HEX(hex_s)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected display from arithmetic on the value: decimal digits by
  // division, hex digits by nibble extraction.
  function automatic logic [55:0] model_hex(input longint v, input bit dec, input int nd);
    logic [55:0] r;
    longint p, q, d;
    bit ovf, seen;
    r = '1;
    p = 1;
    for (int k = 0; k < nd; k++) p = p * 10;
    ovf  = dec ? (v >= p) : ((v >> (4 * nd)) != 0);
    seen = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      if (dec) begin
        q = v;
        for (int k = 0; k < i; k++) q = q / 10;
        d = q % 10;
      end else begin
        d = (v >> (4 * i)) & 15;
      end
      if (ovf)
        r[7*i +: 7] = 7'h3F;
      else if (LZ_EN && d == 0 && !seen && i != 0)
        r[7*i +: 7] = 7'h7F;
      else
        r[7*i +: 7] = glyph_tab[d[3:0]];
      if (d != 0) seen = 1'b1;
    end
    return r;
  endfunction

  // One load on the main instance. Every cycle is checked until one idle
  // cycle after DONE. Ignored loads are injected mid-conversion and in the
  // cycle just before the display update.
  task automatic do_load(input logic [23:0] v, input bit dec);
    int lat;
    logic [55:0] m;
    logic [41:0] exp_new;
    lat = dec ? 25 : 1;
    m = model_hex(longint'(v), dec, 6);
    exp_new = m[41:0];
    @(negedge CLOCK_50);
    VALUE = v; DEC_MODE = dec; LOAD = 1'b1;
    @(negedge CLOCK_50);
    LOAD = 1'b0; VALUE = 24'($urandom); DEC_MODE = 1'($urandom);
    check_eq("busy_start", 64'(BUSY), 64'(dec));
    check_eq("done_start", 64'(DONE), 64'd0);
    check_eq("hex_hold_start", 64'(HEX), 64'(cur_hex));
    for (int j = 1; j <= lat; j++) begin
      if (j == lat || (dec && j == 12)) begin
        LOAD = 1'b1; VALUE = 24'($urandom); DEC_MODE = 1'($urandom);
      end
      @(negedge CLOCK_50);
      LOAD = 1'b0;
      check_eq("busy", 64'(BUSY), 64'(dec && j < lat - 1));
      check_eq("done", 64'(DONE), 64'(j == lat));
      check_eq("hex", 64'(HEX), (j == lat) ? 64'(exp_new) : 64'(cur_hex));
    end
    cur_hex = exp_new;
    VALUE = 24'($urandom);
    @(negedge CLOCK_50);
    check_eq("done_after", 64'(DONE), 64'd0);
    check_eq("hex_after", 64'(HEX), 64'(cur_hex));
  endtask

  task automatic small_load(input logic [7:0] v, input bit dec);
    int n;
    int lat;
    logic [55:0] m;
    lat = dec ? 9 : 1;
    m = model_hex(longint'(v), dec, 2);
    @(negedge CLOCK_50);
    value_s = v; dec_s = dec; load_s = 1'b1;
    @(negedge CLOCK_50);
    load_s = 1'b0; value_s = 8'($urandom);
    n = 0;
    while (!done_s && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    check_eq("s_latency", 64'(n), 64'(lat));
    check_eq("s_hex", 64'(hex_s), 64'(m[13:0]));
    @(negedge CLOCK_50);
  endtask

  initial begin
    logic [23:0] rv;
    KEY0 = 1'b0; VALUE = '0; LOAD = 1'b0; DEC_MODE = 1'b0;
    value_s = '0; load_s = 1'b0; dec_s = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    KEY0 = 1'b1;
    @(negedge CLOCK_50);
    check_eq("rst_hex", 64'(HEX), 64'(42'h3FF_FFFF_FFFF));
    check_eq("rst_busy", 64'(BUSY), 64'd0);
    check_eq("rst_done", 64'(DONE), 64'd0);
    check_eq("rst_hex_s", 64'(hex_s), 64'(14'h3FFF));
    cur_hex = '1;

    do_load(24'h00A3F5, 1'b0);
    do_load(24'd123456, 1'b1);
    do_load(24'd1000000, 1'b1);
    do_load(24'd999999, 1'b1);
    do_load(24'd42, 1'b1);
    do_load(24'd7, 1'b1);
    do_load(24'd0, 1'b1);
    do_load(24'd0, 1'b0);
    do_load(24'hFFFFFF, 1'b1);
    do_load(24'hFFFFFF, 1'b0);
    do_load(24'h000100, 1'b0);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: rv = 24'($urandom % 100);
        1: rv = 24'($urandom);
        2: rv = 24'(999990 + ($urandom % 20));
        default: rv = 24'($urandom % 1000000);
      endcase
      do_load(rv, 1'($urandom));
    end

    // Reset in the middle of a conversion.
    @(negedge CLOCK_50);
    VALUE = 24'd654321; DEC_MODE = 1'b1; LOAD = 1'b1;
    @(negedge CLOCK_50);
    LOAD = 1'b0;
    repeat (10) @(negedge CLOCK_50);
    check_eq("mid_busy", 64'(BUSY), 64'd1);
    KEY0 = 1'b0;
    #1;
    check_eq("mid_rst_hex", 64'(HEX), 64'(42'h3FF_FFFF_FFFF));
    check_eq("mid_rst_busy", 64'(BUSY), 64'd0);
    check_eq("mid_rst_done", 64'(DONE), 64'd0);
    repeat (3) @(negedge CLOCK_50);
    KEY0 = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(negedge CLOCK_50);
      check_eq("post_rst_done", 64'(DONE), 64'd0);
      check_eq("post_rst_hex", 64'(HEX), 64'(42'h3FF_FFFF_FFFF));
    end
    cur_hex = '1;
    do_load(24'd5, 1'b1);

    small_load(8'hFF, 1'b0);
    small_load(8'd100, 1'b1);
    small_load(8'd99, 1'b1);
    small_load(8'h3C, 1'b0);
    for (int t = 0; t < 10; t++) small_load(8'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
